// File: rtl/fwd_pkg.sv
// Shared types and width helpers for the forwarding/hazard unit.
package fwd_pkg;

  typedef enum logic [1:0] {
    RES_ALU   = 2'd0,
    RES_LINK  = 2'd1,
    RES_AUIPC = 2'd2,
    RES_LUI   = 2'd3
  } res_kind_t;

  function automatic int addr_w(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  // Stage select encodes "register file" plus one code per forwarding stage.
  function automatic int stage_w(input int stages);
    return (stages > 0) ? $clog2(stages + 1) : 1;
  endfunction

endpackage

// File: rtl/ll_scoreboard.sv
// Pending-result bitmap for long-latency (mul/div) destinations with a sticky
// error flag for completions that match no outstanding issue.
module ll_scoreboard
  import fwd_pkg::*;
#(
  parameter int NREGS = 32,
  localparam int AW = addr_w(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  input  logic             done_valid,
  input  logic [AW-1:0]    done_rd,
  output logic [NREGS-1:0] pending,
  output logic             sb_err
);

  logic [NREGS-1:0] pending_reg;
  logic [NREGS-1:0] pending_next;
  logic             sb_err_reg;
  logic             sb_err_next;

  // A set in the same cycle as a clear of the same bit wins: the new owner
  // is still outstanding after the old result retires.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign pending_next[gi] = 1'b0;
      end else begin : g_reg
        logic set_bit;
        logic clr_bit;
        assign set_bit = issue_valid && (issue_rd == AW'(gi));
        assign clr_bit = done_valid && (done_rd == AW'(gi));
        assign pending_next[gi] = set_bit | (pending_reg[gi] & ~clr_bit);
      end
    end
  endgenerate

  assign sb_err_next = sb_err_reg | (done_valid & ~pending_reg[done_rd]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= '0;
      sb_err_reg  <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      sb_err_reg  <= sb_err_next;
    end
  end

  assign pending = pending_reg;
  assign sb_err  = sb_err_reg;

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand bypass selection, decode writeback bypass and decode stall
// generation for load-use and long-latency dependencies.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 32,
  localparam int AW = addr_w(NREGS),
  localparam int SW = stage_w(STAGES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [STAGES-1:0]        st_rd_en,
  input  logic [STAGES-1:0][AW-1:0] st_rd_adr,
  input  res_kind_t [STAGES-1:0]   st_kind,
  input  logic                     st_is_load,
  input  logic [AW-1:0]            ex_rs1_adr,
  input  logic [AW-1:0]            ex_rs2_adr,
  input  logic [AW-1:0]            id_rs1_adr,
  input  logic [AW-1:0]            id_rs2_adr,
  input  logic [1:0]               id_rs_used,
  input  logic [AW-1:0]            id_rd_adr,
  input  logic                     id_rd_en,
  input  logic                     ll_issue_valid,
  input  logic [AW-1:0]            ll_issue_rd,
  input  logic                     ll_done_valid,
  input  logic [AW-1:0]            ll_done_rd,
  input  logic                     flush,
  output logic [SW-1:0]            fwd_a_stage,
  output logic [SW-1:0]            fwd_b_stage,
  output res_kind_t                fwd_a_kind,
  output res_kind_t                fwd_b_kind,
  output logic                     id_fwd1,
  output logic                     id_fwd2,
  output logic                     stall,
  output logic                     sb_err,
  output logic [CNT_W-1:0]         stall_cnt
);

  logic [STAGES-1:0] hit_a;
  logic [STAGES-1:0] hit_b;
  logic [NREGS-1:0]  pending;
  logic              issue_ok;
  logic [1:0][AW-1:0] id_rs;
  logic [1:0]        rs_hazard;
  logic              waw_hazard;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic [CNT_W-1:0]  stall_cnt_next;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_hit
      logic writes;
      assign writes    = st_rd_en[gi] && (st_rd_adr[gi] != '0);
      assign hit_a[gi] = writes && (st_rd_adr[gi] == ex_rs1_adr);
      assign hit_b[gi] = writes && (st_rd_adr[gi] == ex_rs2_adr);
    end
  endgenerate

  // Walk oldest to youngest so the youngest matching stage overrides.
  always_comb begin
    fwd_a_stage = '0;
    fwd_a_kind  = RES_ALU;
    fwd_b_stage = '0;
    fwd_b_kind  = RES_ALU;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (hit_a[k]) begin
        fwd_a_stage = SW'(k + 1);
        fwd_a_kind  = st_kind[k];
      end
      if (hit_b[k]) begin
        fwd_b_stage = SW'(k + 1);
        fwd_b_kind  = st_kind[k];
      end
    end
  end

  assign id_fwd1 = st_rd_en[STAGES-1] && (st_rd_adr[STAGES-1] != '0) &&
                   (st_rd_adr[STAGES-1] == id_rs1_adr);
  assign id_fwd2 = st_rd_en[STAGES-1] && (st_rd_adr[STAGES-1] != '0) &&
                   (st_rd_adr[STAGES-1] == id_rs2_adr);

  assign issue_ok = ll_issue_valid && !flush && (ll_issue_rd != '0);

  ll_scoreboard #(
    .NREGS(NREGS)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(issue_ok),
    .issue_rd   (ll_issue_rd),
    .done_valid (ll_done_valid),
    .done_rd    (ll_done_rd),
    .pending    (pending),
    .sb_err     (sb_err)
  );

  assign id_rs = {id_rs2_adr, id_rs1_adr};

  // The issue term covers the cycle before the pending bit becomes visible.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rs
      logic load_use;
      logic ll_owned;
      assign load_use = st_is_load && st_rd_en[0] && (st_rd_adr[0] == id_rs[gi]);
      assign ll_owned = pending[id_rs[gi]] || (issue_ok && (ll_issue_rd == id_rs[gi]));
      assign rs_hazard[gi] = id_rs_used[gi] && (id_rs[gi] != '0) && (load_use || ll_owned);
    end
  endgenerate

  assign waw_hazard = id_rd_en && (id_rd_adr != '0) && pending[id_rd_adr];
  assign stall      = !flush && ((|rs_hazard) || waw_hazard);

  assign stall_cnt_next = (stall && (stall_cnt_reg != '1)) ? stall_cnt_reg + 1'b1
                                                           : stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: expected outputs are queued when stimulus is applied and
// compared against the DUT on the following falling edge.
module tb_fwd_hazard_unit;
  import fwd_pkg::*;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [1:0]       st_rd_en;
  logic [1:0][4:0]  st_rd_adr;
  res_kind_t [1:0]  st_kind;
  logic             st_is_load;
  logic [4:0]       ex_rs1_adr, ex_rs2_adr, id_rs1_adr, id_rs2_adr, id_rd_adr;
  logic [1:0]       id_rs_used;
  logic             id_rd_en;
  logic             ll_issue_valid, ll_done_valid, flush;
  logic [4:0]       ll_issue_rd, ll_done_rd;
  logic [1:0]       fwd_a_stage, fwd_b_stage;
  res_kind_t        fwd_a_kind, fwd_b_kind;
  logic             id_fwd1, id_fwd2, stall, sb_err;
  logic [CNT_W-1:0] stall_cnt;

  fwd_hazard_unit #(.NREGS(32), .STAGES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .st_rd_en(st_rd_en), .st_rd_adr(st_rd_adr),
    .st_kind(st_kind), .st_is_load(st_is_load), .ex_rs1_adr(ex_rs1_adr),
    .ex_rs2_adr(ex_rs2_adr), .id_rs1_adr(id_rs1_adr), .id_rs2_adr(id_rs2_adr),
    .id_rs_used(id_rs_used), .id_rd_adr(id_rd_adr), .id_rd_en(id_rd_en),
    .ll_issue_valid(ll_issue_valid), .ll_issue_rd(ll_issue_rd),
    .ll_done_valid(ll_done_valid), .ll_done_rd(ll_done_rd), .flush(flush),
    .fwd_a_stage(fwd_a_stage), .fwd_b_stage(fwd_b_stage),
    .fwd_a_kind(fwd_a_kind), .fwd_b_kind(fwd_b_kind),
    .id_fwd1(id_fwd1), .id_fwd2(id_fwd2), .stall(stall), .sb_err(sb_err),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a_stage; int a_kind; int b_stage; int b_kind;
    int fwd1; int fwd2; int stall; int err; int cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pending;
  int          m_err;
  int          m_cnt;
  int          n_checks;
  int          n_pass;

  task automatic check_val(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  function automatic bit rs_hz(input logic [4:0] rs);
    if (rs == 0) return 1'b0;
    return (st_is_load && st_rd_en[0] && st_rd_adr[0] == rs) || m_pending[rs] ||
           (ll_issue_valid && !flush && ll_issue_rd == rs);
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    e.a_stage = 0; e.a_kind = int'(RES_ALU);
    e.b_stage = 0; e.b_kind = int'(RES_ALU);
    for (int k = 0; k < 2; k++) begin
      if (e.a_stage == 0 && st_rd_en[k] && st_rd_adr[k] != 0 && st_rd_adr[k] == ex_rs1_adr) begin
        e.a_stage = k + 1; e.a_kind = int'(st_kind[k]);
      end
      if (e.b_stage == 0 && st_rd_en[k] && st_rd_adr[k] != 0 && st_rd_adr[k] == ex_rs2_adr) begin
        e.b_stage = k + 1; e.b_kind = int'(st_kind[k]);
      end
    end
    e.fwd1  = int'(st_rd_en[1] && st_rd_adr[1] != 0 && st_rd_adr[1] == id_rs1_adr);
    e.fwd2  = int'(st_rd_en[1] && st_rd_adr[1] != 0 && st_rd_adr[1] == id_rs2_adr);
    e.stall = int'(!flush && ((id_rs_used[0] && rs_hz(id_rs1_adr)) ||
                              (id_rs_used[1] && rs_hz(id_rs2_adr)) ||
                              (id_rd_en && id_rd_adr != 0 && m_pending[id_rd_adr])));
    e.err = m_err;
    e.cnt = m_cnt;
    return e;
  endfunction

  task automatic model_update(input exp_t e);
    if (e.stall != 0 && m_cnt != CNT_MAX) m_cnt++;
    if (ll_done_valid) begin
      if (!m_pending[ll_done_rd]) m_err = 1;
      else m_pending[ll_done_rd] = 1'b0;
    end
    if (ll_issue_valid && !flush && ll_issue_rd != 0) m_pending[ll_issue_rd] = 1'b1;
  endtask

  task automatic compare_head(input string tag);
    exp_t g;
    g = exp_q.pop_front();
    check_val({tag, ".a_stage"}, int'(fwd_a_stage), g.a_stage);
    check_val({tag, ".a_kind"},  int'(fwd_a_kind),  g.a_kind);
    check_val({tag, ".b_stage"}, int'(fwd_b_stage), g.b_stage);
    check_val({tag, ".b_kind"},  int'(fwd_b_kind),  g.b_kind);
    check_val({tag, ".id_fwd1"}, int'(id_fwd1),     g.fwd1);
    check_val({tag, ".id_fwd2"}, int'(id_fwd2),     g.fwd2);
    check_val({tag, ".stall"},   int'(stall),       g.stall);
    check_val({tag, ".sb_err"},  int'(sb_err),      g.err);
    check_val({tag, ".cnt"},     int'(stall_cnt),   g.cnt);
    $display("txn %-12s a=%0d b=%0d stall=%0d err=%0d cnt=%0d",
             tag, fwd_a_stage, fwd_b_stage, stall, sb_err, stall_cnt);
  endtask

  // Called just after a rising edge with the cycle's inputs already applied.
  task automatic step(input string tag);
    exp_t e;
    e = model_outputs();
    exp_q.push_back(e);
    @(negedge clk);
    compare_head(tag);
    @(posedge clk);
    if (rst_n) model_update(e);
    #1;
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    m_pending = '0; m_err = 0; m_cnt = 0;
    exp_q.push_back(model_outputs());
    #1 compare_head(tag);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic idle();
    st_rd_en = '0; st_rd_adr = '0; st_kind = {RES_ALU, RES_ALU}; st_is_load = 0;
    ex_rs1_adr = 0; ex_rs2_adr = 0; id_rs1_adr = 0; id_rs2_adr = 0; id_rs_used = 0;
    id_rd_adr = 0; id_rd_en = 0; ll_issue_valid = 0; ll_issue_rd = 0;
    ll_done_valid = 0; ll_done_rd = 0; flush = 0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    m_pending = '0; m_err = 0; m_cnt = 0;
    rst_n = 1'b0;
    idle();
    #1 step("reset");
    rst_n = 1'b1;

    // EX forwarding priority between stages
    st_rd_en = 2'b11; st_rd_adr[0] = 5; st_rd_adr[1] = 5;
    st_kind[0] = RES_ALU; st_kind[1] = RES_LINK; ex_rs1_adr = 5;
    step("fwd_young");
    st_rd_en = 2'b10;
    step("fwd_old");

    // x0 never forwards; decode bypass from the oldest stage
    idle();
    st_rd_en = 2'b11; st_rd_adr[0] = 0; st_rd_adr[1] = 7; st_kind[1] = RES_LUI;
    ex_rs2_adr = 0; id_rs1_adr = 7;
    step("zero_rd");
    ex_rs2_adr = 7; id_rs2_adr = 7; st_kind[0] = RES_AUIPC;
    step("b_old_lui");

    // load-use
    idle();
    st_is_load = 1; st_rd_en = 2'b01; st_rd_adr[0] = 3; id_rs2_adr = 3; id_rs_used = 2'b10;
    step("load_use");
    id_rs_used = 2'b00;
    step("load_unused");
    id_rs_used = 2'b10; flush = 1;
    step("flush_stall");

    // pending entry, sticky error, then reset mid-operation
    idle();
    ll_issue_valid = 1; ll_issue_rd = 4;
    step("issue4");
    idle();
    id_rs1_adr = 4; id_rs_used = 2'b01;
    step("pend4");
    ll_done_valid = 1; ll_done_rd = 13;
    step("done13_err");
    ll_done_valid = 0;
    step("err_sticky");
    async_reset("async_rst");
    idle();
    flush = 1; ll_issue_valid = 1; ll_issue_rd = 6; id_rs1_adr = 6; id_rs_used = 2'b01;
    step("flush_issue");
    idle();
    id_rs1_adr = 6; id_rs_used = 2'b01;
    step("no_pend6");

    // long-latency dependency: stall N..N+4, release at N+5
    ll_issue_valid = 1; ll_issue_rd = 9; id_rs1_adr = 9; id_rs_used = 2'b01;
    step("ll_n0");
    ll_issue_valid = 0;
    for (int i = 1; i < 4; i++) step("ll_wait");
    ll_done_valid = 1; ll_done_rd = 9;
    step("ll_n4");
    ll_done_valid = 0;
    step("ll_n5");
    check_val("ll_cnt5", int'(stall_cnt), 5);

    // set wins over clear on the same register, then error on a free one
    idle();
    ll_issue_valid = 1; ll_issue_rd = 12;
    step("issue12");
    ll_done_valid = 1; ll_done_rd = 12;
    step("set_clr12");
    idle();
    id_rs1_adr = 12; id_rs_used = 2'b01;
    step("pend12");
    ll_done_valid = 1; ll_done_rd = 13;
    step("done13");
    ll_done_valid = 0;
    for (int i = 0; i < 3; i++) step("saturate");
    check_val("cnt_sat", int'(stall_cnt), CNT_MAX);

    // write-after-write on a pending destination
    idle();
    id_rd_en = 1; id_rd_adr = 12;
    step("waw");
    id_rd_en = 0; ll_done_valid = 1; ll_done_rd = 12;
    step("done12");
    idle();
    id_rd_en = 1; id_rd_adr = 12;
    step("waw_clear");

    async_reset("rst2");
    for (int i = 0; i < 60; i++) begin
      st_rd_en = 2'($urandom);
      st_rd_adr[0] = 5'($urandom_range(0, 7)); st_rd_adr[1] = 5'($urandom_range(0, 7));
      st_kind[0] = res_kind_t'($urandom_range(0, 3)); st_kind[1] = res_kind_t'($urandom_range(0, 3));
      st_is_load = 1'($urandom);
      ex_rs1_adr = 5'($urandom_range(0, 7)); ex_rs2_adr = 5'($urandom_range(0, 7));
      id_rs1_adr = 5'($urandom_range(0, 7)); id_rs2_adr = 5'($urandom_range(0, 7));
      id_rs_used = 2'($urandom);
      id_rd_en = 1'($urandom); id_rd_adr = 5'($urandom_range(0, 7));
      ll_issue_valid = ($urandom_range(0, 3) == 0); ll_issue_rd = 5'($urandom_range(0, 7));
      ll_done_valid = ($urandom_range(0, 3) == 0); ll_done_rd = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the RV32I pipeline, replacing the fixed two-stage forwarding block. It selects the bypass source for both EX-stage operands across a configurable number of downstream stages, each carrying a typed result (ALU, link, AUIPC, LUI). It also provides decode-stage writeback bypass and generates a decode stall for load-use hazards and for results owned by a long-latency unit (mul/div). A clocked scoreboard tracks those long-latency results and a saturating counter records stall cycles.

## Interface
Parameters:
- NREGS, 32, architectural register count (power of two; index 0 hard-wired zero)
- STAGES, 2, forwarding stages after EX; stage 0 = EX/MEM (youngest), stage STAGES-1 = MEM/WB (oldest)
- CNT_W, 32, stall counter width

Ports (AW = clog2(NREGS), SW = clog2(STAGES+1)):
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- st_rd_en  in  STAGES  per-stage register write enable
- st_rd_adr  in  STAGES×AW  per-stage destination register
- st_kind  in  STAGES×res_kind_t  per-stage result kind
- st_is_load  in  1  stage-0 instruction is a load (data not yet available)
- ex_rs1_adr, ex_rs2_adr  in  AW each  EX-stage source registers
- id_rs1_adr, id_rs2_adr  in  AW each  decode-stage source registers
- id_rs_used  in  2  decode instruction reads rs1 / rs2
- id_rd_adr  in  AW  decode-stage destination register
- id_rd_en  in  1  decode instruction writes rd
- ll_issue_valid  in  1  long-latency op leaving EX this cycle
- ll_issue_rd  in  AW  its destination
- ll_done_valid  in  1  long-latency result written back this cycle
- ll_done_rd  in  AW  its destination
- flush  in  1  squash ID/EX; cancels same-cycle ll_issue
- fwd_a_stage, fwd_b_stage  out  SW each  0 = register file, k = stage k-1
- fwd_a_kind, fwd_b_kind  out  res_kind_t each  kind of selected source (RES_ALU when stage 0)
- id_fwd1, id_fwd2  out  1 each  decode operand bypassed from stage STAGES-1
- stall  out  1  hold PC and IF/ID, bubble ID/EX
- sb_err  out  1  sticky: ll_done for non-pending register
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- EX forwarding, per operand: youngest stage k with st_rd_en[k], st_rd_adr[k]!=0, st_rd_adr[k]==ex_rsX_adr wins; output stage=k+1 and kind=st_kind[k]. No match -> stage 0, RES_ALU.
- Decode bypass: id_fwdN=1 when stage STAGES-1 writes a nonzero rd equal to id_rsN_adr.
- Scoreboard: pending[NREGS] bitmap. Set bit on ll_issue_valid & !flush & ll_issue_rd!=0. Clear on ll_done_valid. Simultaneous set and clear of same bit -> set wins. ll_done for clear bit -> no change, sb_err=1 until reset.
- stall (combinational) = any of, for each used id rs!=0:
  - load-use: st_is_load & st_rd_en[0] & st_rd_adr[0]==rs
  - pending[rs], or ll_issue_valid & !flush & ll_issue_rd==rs
  - WAW: id_rd_en & id_rd_adr!=0 & pending[id_rd_adr]
- flush forces stall=0 that cycle.
- stall_cnt increments each cycle stall=1; holds at all-ones.

## Timing
- Forward selects, id_fwd, stall: combinational, zero latency.
- pending update visible the cycle after issue/done; same-cycle issue covered by bypass term in stall.
- ll_done at cycle N releases dependent decode at N+1 (stall low at N+1).
- Reset (async assert, sync-to-clk deassert upstream): pending=0, sb_err=0, stall_cnt=0; combinational outputs follow inputs immediately. Reset mid-operation drops all pending entries.

## Structure
- Package fwd_pkg: res_kind_t enum {RES_ALU, RES_LINK, RES_AUIPC, RES_LUI} (2 bits), SW/AW helper functions.
- One sub-module: ll_scoreboard (pending bitmap, set/clear priority, sb_err). Priority encoder and stall logic stay in top.

## Test plan
- Stage0 rd=5 ALU and stage1 rd=5 LINK, ex_rs1=5 -> fwd_a_stage=1, kind RES_ALU; drop stage0 enable -> stage=2, RES_LINK.
- Stage0 rd=0 write, ex_rs2=0 -> fwd_b_stage=0; stage1 rd=7 LUI, id_rs1=7 -> id_fwd1=1.
- Stage0 load rd=3, id_rs2=3 used -> stall=1, stall_cnt 0->1; id_rs_used=0 -> stall=0.
- ll_issue rd=9 at N, id_rs1=9 at N..N+4, ll_done rd=9 at N+4 -> stall 1 for N..N+4, 0 at N+5; stall_cnt=5.
- Same-cycle ll_issue and ll_done rd=12 -> pending[12]=1 next cycle; ll_done rd=13 unpending -> sb_err=1 sticky.
- Set pending rd=4, assert rst_n low mid-cycle -> pending, sb_err, stall_cnt cleared immediately; flush with ll_issue rd=6 -> pending[6]=0.
